alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that drives one 1-bit ALU slice (A, B, Binvert, CarryIn, 3-bit Operation -> Result, CarryOut) across WIDTH consecutive cycles to produce a WIDTH-bit result.
- Owns operand/result shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.
- Used where area matters more than latency; the slice itself stays combinational and external.

---
 rtl/alu_serial_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving an external 1-bit ALU slice over WIDTH cycles.
// Latency: start accepted at edge T -> busy cycles T..T+WIDTH-1, done pulse in cycle T+WIDTH.
// Backpressure: none; start is ignored while busy, and a start held in DONE chains the next op.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_binvert,
    output logic             slice_cin,
    output logic [2:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] assembled;
    logic             is_arith;
    logic             accept;

    // Result bits arrive LSB first, so each new bit enters at the top.
    assign assembled = {slice_result, acc_q[WIDTH-1:1]};

    always_comb begin
        is_arith = 1'b1;
        case (op_q)
            OP_AND, OP_OR, OP_NAND, OP_NOR: is_arith = 1'b0;
            default:                        is_arith = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        accept   = 1'b0;

        case (state_q)
            S_IDLE: begin
                accept = start;
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                acc_d   = assembled;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d  = S_DONE;
                    result_d = assembled;
                    zero_d   = (assembled == '0);
                    // carry_q here is the carry into the MSB, so XOR with carry out flags signed overflow.
                    cout_d   = is_arith ? slice_cout : 1'b0;
                    ovf_d    = is_arith ? (slice_cout ^ carry_q) : 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                accept  = start;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d = S_RUN;
            a_d     = a;
            b_d     = b;
            op_d    = op;
            cnt_d   = '0;
            carry_d = (op == OP_SUB);
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign result        = result_q;
    assign carry_out     = cout_q;
    assign overflow      = ovf_q;
    assign zero          = zero_q;
    assign slice_a       = busy ? a_q[0] : 1'b0;
    assign slice_b       = busy ? b_q[0] : 1'b0;
    assign slice_cin     = busy ? carry_q : 1'b0;
    assign slice_op      = op_q;
    assign slice_binvert = (op_q == OP_SUB);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (WIDTH=8) with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         slice_a;
    logic         slice_b;
    logic         slice_binvert;
    logic         slice_cin;
    logic [2:0]   slice_op;
    logic         slice_result;
    logic         slice_cout;

    int n_cmp = 0;
    int n_err = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .a            (a),
        .b            (b),
        .op           (op),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .carry_out    (carry_out),
        .overflow     (overflow),
        .zero         (zero),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_binvert(slice_binvert),
        .slice_cin    (slice_cin),
        .slice_op     (slice_op),
        .slice_result (slice_result),
        .slice_cout   (slice_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-bit ALU slice.
    logic bb;
    logic sum_bit;
    always_comb begin
        bb           = slice_b ^ slice_binvert;
        sum_bit      = slice_a ^ bb ^ slice_cin;
        slice_cout   = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
        slice_result = sum_bit;
        case (slice_op)
            3'b000:  slice_result = slice_a & slice_b;
            3'b001:  slice_result = slice_a | slice_b;
            3'b011:  slice_result = ~(slice_a & slice_b);
            3'b100:  slice_result = ~(slice_a | slice_b);
            default: slice_result = sum_bit;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] opv);
        @(negedge clk);
        a     = av;
        b     = bv;
        op    = opv;
        start = 1'b1;
    endtask

    // Cycle index 0 is the first cycle after the accept edge; returns when done is seen.
    task automatic wait_done(input bit hammer, output int nbusy, output int didx,
                             output bit binv, output bit cin0, output logic [W-1:0] res0);
        nbusy = 0;
        didx  = -1;
        binv  = 1'b0;
        cin0  = 1'b0;
        res0  = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hammer) begin
                start = 1'b1;
                a     = 8'(8'hA5 + k);
                b     = 8'(8'h5A ^ k);
                op    = 3'b011;
            end else begin
                start = 1'b0;
            end
            if (k == 0) begin
                cin0 = slice_cin;
                res0 = result;
            end
            if (busy) nbusy++;
            binv = binv | slice_binvert;
            if (done) begin
                didx = k;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [2:0] opv, input logic [W-1:0] er, input bit ec,
                             input bit eo, input bit ez, input bit eb);
        int nb;
        int di;
        bit bs;
        bit c0;
        logic [W-1:0] r0;
        issue(av, bv, opv);
        wait_done(1'b0, nb, di, bs, c0, r0);
        chk({tag, ".done_idx"}, 64'(di), 64'(W));
        chk({tag, ".result"}, 64'(result), 64'(er));
        chk({tag, ".carry"}, 64'(carry_out), 64'(ec));
        chk({tag, ".ovf"}, 64'(overflow), 64'(eo));
        chk({tag, ".zero"}, 64'(zero), 64'(ez));
        chk({tag, ".binv"}, 64'(bs), 64'(eb));
    endtask

    int nb;
    int di;
    bit bs;
    bit c0;
    logic [W-1:0] r0;
    int ndone;
    int nbusy_after;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.slice_op", 64'(slice_op), 64'd0);
        chk("rst.binv", 64'(slice_binvert), 64'd0);
        chk("rst.cin", 64'(slice_cin), 64'd0);
        reset = 1'b0;

        // ADD with signed overflow, plus latency and pulse width.
        issue(8'h7F, 8'h01, 3'b010);
        wait_done(1'b0, nb, di, bs, c0, r0);
        chk("add.busy_cycles", 64'(nb), 64'd8);
        chk("add.done_idx", 64'(di), 64'd8);
        chk("add.result", 64'(result), 64'h80);
        chk("add.carry", 64'(carry_out), 64'd0);
        chk("add.ovf", 64'(overflow), 64'd1);
        chk("add.zero", 64'(zero), 64'd0);
        @(negedge clk);
        chk("add.done_pulse", 64'(done), 64'd0);
        chk("add.idle_busy", 64'(busy), 64'd0);
        chk("add.result_held", 64'(result), 64'h80);

        // SUB cases; carry into bit 0 must start at 1.
        issue(8'h05, 8'h05, 3'b110);
        wait_done(1'b0, nb, di, bs, c0, r0);
        chk("sub0.cin0", 64'(c0), 64'd1);
        chk("sub0.result", 64'(result), 64'h00);
        chk("sub0.zero", 64'(zero), 64'd1);
        chk("sub0.carry", 64'(carry_out), 64'd1);
        chk("sub0.ovf", 64'(overflow), 64'd0);
        chk("sub0.binv", 64'(bs), 64'd1);
        run_check("sub1", 8'h80, 8'h01, 3'b110, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);

        // Logic operations.
        run_check("and",  8'hF0, 8'h3C, 3'b000, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        run_check("or",   8'hF0, 8'h3C, 3'b001, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0);
        run_check("nand", 8'hF0, 8'h3C, 3'b011, 8'hCF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_check("nor",  8'hF0, 8'h3C, 3'b100, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start hammered during RUN is ignored; start in DONE chains a SUB back-to-back.
        issue(8'h12, 8'h34, 3'b010);
        wait_done(1'b1, nb, di, bs, c0, r0);
        chk("b2b.first_idx", 64'(di), 64'd8);
        chk("b2b.first_result", 64'(result), 64'h46);
        chk("b2b.first_carry", 64'(carry_out), 64'd0);
        a     = 8'h20;
        b     = 8'h03;
        op    = 3'b110;
        start = 1'b1;
        wait_done(1'b0, nb, di, bs, c0, r0);
        chk("b2b.second_busy", 64'(nb), 64'd8);
        chk("b2b.second_idx", 64'(di), 64'd8);
        chk("b2b.result_held", 64'(r0), 64'h46);
        chk("b2b.second_result", 64'(result), 64'h1D);
        chk("b2b.second_carry", 64'(carry_out), 64'd1);

        // Reset in the middle of a run.
        issue(8'h55, 8'h22, 3'b010);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort.busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.result", 64'(result), 64'd0);
        chk("abort.carry", 64'(carry_out), 64'd0);
        chk("abort.slice_op", 64'(slice_op), 64'd0);
        ndone       = 0;
        nbusy_after = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy_after++;
        end
        chk("abort.no_done", 64'(ndone), 64'd0);
        chk("abort.no_busy", 64'(nbusy_after), 64'd0);
        run_check("after_abort", 8'h01, 8'h01, 3'b010, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

        // Unused opcode behaves as ADD.
        run_check("op111", 8'h0F, 8'h01, 3'b111, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("op111.slice_op", 64'(slice_op), 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
